uart_ctrl: RTL

Memory-mapped UART controller for the single-cycle MIPS core's peripheral space. Sits downstream of the CPU's peripheral bus decode (selected when the data address has bit 30 set) and drives the board `rx`/`tx` pins. Provides 8N1 transmit and receive, a status/control register and a level interrupt contributing to the core's IRQ line.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_core.sv | 85 ++++++++
 rtl/uart_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register addresses, CON bit positions, FSM states.
// Build option UART_RX_FIFO_EN (see uart_ctrl) selects a 4-entry RX FIFO instead of a holding register.
package uart_pkg;

    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

    localparam int CON_TX_IRQ_EN = 0;
    localparam int CON_RX_IRQ_EN = 1;
    localparam int CON_TX_DONE   = 2;
    localparam int CON_RX_VALID  = 3;
    localparam int CON_TX_BUSY   = 4;
    localparam int CON_OVERRUN   = 5;
    localparam int CON_FRAME_ERR = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: two-flop synchronizer plus mid-bit sampling FSM; pulses rx_strobe (good byte)
// or rx_ferr (bad stop bit) for one cycle, combinationally during the stop-bit sample cycle.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_strobe,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic          r_sync1;
    logic          r_sync2;
    uart_state_e   r_state;
    uart_state_e   w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_cnt_end;
    logic          w_cnt_half;

    assign w_cnt_end  = (r_cnt == CNT_MAX);
    assign w_cnt_half = (r_cnt == CNT_HALF);
    assign rx_byte    = r_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        rx_strobe   = 1'b0;
        rx_ferr     = 1'b0;
        case (r_state)
            IDLE:  if (!r_sync2) w_state_nxt = START;
            // A start bit that is high again at mid-bit was only a glitch.
            START: if (w_cnt_half) w_state_nxt = r_sync2 ? IDLE : DATA;
            DATA:  if (w_cnt_end && (r_bit == 3'd7)) w_state_nxt = STOP;
            STOP: begin
                if (w_cnt_end) begin
                    w_state_nxt = IDLE;
                    rx_strobe   = r_sync2;
                    rx_ferr     = !r_sync2;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == IDLE) || (r_state != w_state_nxt) || w_cnt_end)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (r_state != DATA)
                r_bit <= 3'd0;
            else if (w_cnt_end)
                r_bit <= r_bit + 3'd1;
            if ((r_state == DATA) && w_cnt_end)
                r_shift <= {r_sync2, r_shift[7:1]};
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON registers, level irq) on the CPU peripheral bus.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX uses a single holding register.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rx,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic w_txd_wr, w_con_wr, w_rxd_rd, w_con_rd;
    assign w_txd_wr = wr && (addr == UART_TXD_ADDR);
    assign w_con_wr = wr && (addr == UART_CON_ADDR);
    assign w_rxd_rd = rd && (addr == UART_RXD_ADDR);
    assign w_con_rd = rd && (addr == UART_CON_ADDR);

    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, wdata[31:8]};

    uart_state_e   r_tx_state, w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_txd;
    logic          r_tx, w_tx_nxt, w_tx_done_set, w_tx_busy, w_tx_cnt_end;

    assign w_tx_cnt_end = (r_tx_cnt == CNT_MAX);
    assign w_tx_busy    = (r_tx_state != IDLE);
    assign tx           = r_tx;

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_done_set  = 1'b0;
        w_tx_nxt       = 1'b1;
        case (r_tx_state)
            IDLE:  if (w_txd_wr) w_tx_state_nxt = START;
            START: if (w_tx_cnt_end) w_tx_state_nxt = DATA;
            DATA: begin
                if (w_tx_cnt_end) begin
                    w_tx_bit_nxt = r_tx_bit + 3'd1;
                    if (r_tx_bit == 3'd7) w_tx_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_tx_cnt_end) begin
                    w_tx_state_nxt = IDLE;
                    w_tx_done_set  = 1'b1;
                end
            end
            default: w_tx_state_nxt = IDLE;
        endcase
        // The pin is registered from the next state so it never glitches on decode.
        case (w_tx_state_nxt)
            START:   w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = r_txd[w_tx_bit_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_state <= IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_txd      <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx       <= w_tx_nxt;
            if ((r_tx_state == IDLE) || w_tx_cnt_end)
                r_tx_cnt <= '0;
            else
                r_tx_cnt <= r_tx_cnt + 1'b1;
            if (w_txd_wr && (r_tx_state == IDLE))
                r_txd <= wdata[7:0];
        end
    end

    logic       w_rx_strobe, w_rx_ferr;
    logic [7:0] w_rx_byte;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_core (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_strobe (w_rx_strobe),
        .rx_byte   (w_rx_byte),
        .rx_ferr   (w_rx_ferr)
    );

    logic       w_rx_valid, w_rx_pop, w_rx_push, w_ovr_set;
    logic [7:0] w_rx_head;

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wptr, r_rptr;
    logic [2:0] r_count;
    logic       w_full;

    assign w_full     = (r_count == 3'd4);
    assign w_rx_valid = (r_count != 3'd0);
    assign w_rx_pop   = w_rxd_rd && w_rx_valid;
    assign w_rx_push  = w_rx_strobe && (!w_full || w_rx_pop);
    assign w_ovr_set  = w_rx_strobe && w_full && !w_rx_pop;
    assign w_rx_head  = r_fifo[r_rptr];

    always_ff @(posedge clk) begin
        if (w_rx_push) r_fifo[r_wptr] <= w_rx_byte;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_rx_push) r_wptr <= r_wptr + 2'd1;
            if (w_rx_pop)  r_rptr <= r_rptr + 2'd1;
            r_count <= r_count + {2'b00, w_rx_push} - {2'b00, w_rx_pop};
        end
    end
`else
    logic [7:0] r_rx_data;
    logic       r_rx_vld;

    assign w_rx_valid = r_rx_vld;
    assign w_rx_pop   = w_rxd_rd && r_rx_vld;
    assign w_rx_push  = w_rx_strobe && (!r_rx_vld || w_rx_pop);
    assign w_ovr_set  = w_rx_strobe && r_rx_vld && !w_rx_pop;
    assign w_rx_head  = r_rx_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rx_data <= 8'h00;
            r_rx_vld  <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_data <= w_rx_byte;
            r_rx_vld <= w_rx_push | (r_rx_vld & ~w_rx_pop);
        end
    end
`endif

    logic r_tx_irq_en, r_rx_irq_en, r_tx_done, r_overrun, r_frame_err, r_irq;

    // Sticky bits: a new event in the clearing cycle wins so it is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_irq_en <= 1'b0;
            r_rx_irq_en <= 1'b0;
            r_tx_done   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            if (w_con_wr) begin
                r_tx_irq_en <= wdata[CON_TX_IRQ_EN];
                r_rx_irq_en <= wdata[CON_RX_IRQ_EN];
            end
            r_tx_done   <= w_tx_done_set | (r_tx_done & ~w_con_rd);
            r_overrun   <= w_ovr_set | (r_overrun & ~w_con_rd);
            r_frame_err <= w_rx_ferr | (r_frame_err & ~w_con_rd);
            r_irq       <= (r_tx_irq_en & r_tx_done) | (r_rx_irq_en & w_rx_valid);
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = 32'h0;
        if (rd) begin
            case (addr)
                UART_TXD_ADDR: rdata = {24'h0, r_txd};
                UART_RXD_ADDR: if (w_rx_valid) rdata = {24'h0, w_rx_head};
                UART_CON_ADDR: begin
                    rdata[CON_TX_IRQ_EN] = r_tx_irq_en;
                    rdata[CON_RX_IRQ_EN] = r_rx_irq_en;
                    rdata[CON_TX_DONE]   = r_tx_done;
                    rdata[CON_RX_VALID]  = w_rx_valid;
                    rdata[CON_TX_BUSY]   = w_tx_busy;
                    rdata[CON_OVERRUN]   = r_overrun;
                    rdata[CON_FRAME_ERR] = r_frame_err;
                end
                default: rdata = 32'h0;
            endcase
        end
    end

endmodule
